// File: rtl/ram_arb_pkg.sv
// Shared encodings for the block-RAM arbiter: grant owner and read-pipe state.
// Optional feature macro: RAM_ARB_ROUND_ROBIN_EN (see ram_arbiter.sv).
package ram_arb_pkg;

    // Who owns the RAM port in a given cycle
    typedef enum logic [1:0] {
        OWNER_NONE = 2'd0,
        OWNER_CPU  = 2'd1,
        OWNER_DMA  = 2'd2
    } owner_e;

    // Whose read data appears on ram_q in the following cycle
    typedef enum logic [1:0] {
        RD_IDLE = 2'd0,
        RD_CPU  = 2'd1,
        RD_DMA  = 2'd2
    } rd_state_e;

    // Map a grant owner plus write flag to the read-pipe state it launches
    function automatic rd_state_e rd_launch(input owner_e own, input logic we);
        rd_state_e st;
        st = RD_IDLE;
        if (!we) begin
            if (own == OWNER_CPU) st = RD_CPU;
            if (own == OWNER_DMA) st = RD_DMA;
        end
        return st;
    endfunction

endpackage

// File: rtl/ram_arb_wait_cnt.sv
// Saturating counter bounding how long a pending CPU read may lose to DMA.
// Clear has priority over increment; o_at_limit flags the saturation value.
module ram_arb_wait_cnt
    import ram_arb_pkg::*;
#(
    parameter int MAX = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic i_clr,
    input  logic i_inc,
    output logic o_at_limit
);

    localparam int W = (MAX < 1) ? 1 : $clog2(MAX + 1);
    localparam logic [W-1:0] LIM = W'(MAX);

    logic [W-1:0] r_cnt;

    // Count lost arbitration cycles, holding at the limit
    always_ff @(posedge clk) begin
        if (reset || i_clr) begin
            r_cnt <= '0;
        end else if (i_inc && (r_cnt != LIM)) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign o_at_limit = (r_cnt == LIM);

endmodule

// File: rtl/ram_arbiter.sv
// Arbitrates the single-port system RAM between CPU bus and DMA/video fetch.
// Macro RAM_ARB_ROUND_ROBIN_EN: alternate CPU-read/DMA contention winners.
module ram_arbiter
    import ram_arb_pkg::*;
#(
    parameter int ADDR_WIDTH = 16,
    parameter int DATA_WIDTH = 8,
    parameter int MAX_WAIT   = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [ADDR_WIDTH-1:0] cpu_addr,
    input  logic                  cpu_rd_req,
    input  logic                  cpu_wr_en,
    input  logic [DATA_WIDTH-1:0] cpu_wr_data,
    output logic [DATA_WIDTH-1:0] cpu_rd_data,
    output logic                  cpu_ready,
    input  logic [ADDR_WIDTH-1:0] dma_addr,
    input  logic                  dma_req,
    input  logic                  dma_we,
    input  logic [DATA_WIDTH-1:0] dma_wr_data,
    output logic                  dma_ack,
    output logic                  dma_rd_valid,
    output logic [DATA_WIDTH-1:0] dma_rd_data,
    output logic [ADDR_WIDTH-1:0] ram_addr,
    output logic [DATA_WIDTH-1:0] ram_wr_data,
    output logic                  ram_wren,
    input  logic [DATA_WIDTH-1:0] ram_q
);

    logic                  r_pend;
    logic [ADDR_WIDTH-1:0] r_pend_addr;
    logic [ADDR_WIDTH-1:0] r_last_addr;
    logic                  r_ready;
    logic [DATA_WIDTH-1:0] r_rd_data;
    rd_state_e             r_rd_state;
    rd_state_e             w_rd_state_nxt;

    logic                  w_rd_live;
    logic [ADDR_WIDTH-1:0] w_rd_addr;
    logic                  w_cpu_wins;
    logic                  w_cpu_rd_gnt;
    logic                  w_dma_gnt;
    logic                  w_wren;
    logic [ADDR_WIDTH-1:0] w_addr;
    logic [DATA_WIDTH-1:0] w_wdata;
    owner_e                w_owner;

    // A read is live on its request cycle or while it waits in the pend slot
    assign w_rd_live = cpu_rd_req | r_pend;
    assign w_rd_addr = r_pend ? r_pend_addr : cpu_addr;

`ifdef RAM_ARB_ROUND_ROBIN_EN
    owner_e r_last_owner;
    logic   w_contend;

    assign w_contend  = !reset && !cpu_wr_en && w_rd_live && dma_req;
    assign w_cpu_wins = (r_last_owner != OWNER_CPU);

    // Remember who won the last CPU-read/DMA contention
    always_ff @(posedge clk) begin
        if (reset) begin
            r_last_owner <= OWNER_CPU;
        end else if (w_contend) begin
            r_last_owner <= w_owner;
        end
    end
`else
    logic w_at_limit;

    ram_arb_wait_cnt #(
        .MAX(MAX_WAIT)
    ) u_wait_cnt (
        .clk       (clk),
        .reset     (reset),
        .i_clr     (w_cpu_rd_gnt),
        .i_inc     (r_pend & w_dma_gnt),
        .o_at_limit(w_at_limit)
    );

    assign w_cpu_wins = (MAX_WAIT == 0) || w_at_limit;
`endif

    // Pick this cycle's single RAM owner: CPU write, CPU read, then DMA
    always_comb begin
        w_cpu_rd_gnt = 1'b0;
        w_dma_gnt    = 1'b0;
        w_wren       = 1'b0;
        w_addr       = r_last_addr;
        w_wdata      = cpu_wr_data;
        w_owner      = OWNER_NONE;
        if (reset) begin
            w_owner = OWNER_NONE;
        end else if (cpu_wr_en) begin
            w_wren  = 1'b1;
            w_addr  = cpu_addr;
            w_owner = OWNER_CPU;
        end else if (w_rd_live && (!dma_req || w_cpu_wins)) begin
            w_cpu_rd_gnt = 1'b1;
            w_addr       = w_rd_addr;
            w_owner      = OWNER_CPU;
        end else if (dma_req) begin
            w_dma_gnt = 1'b1;
            w_wren    = dma_we;
            w_addr    = dma_addr;
            w_wdata   = dma_wr_data;
            w_owner   = OWNER_DMA;
        end
    end

    // Decide whose data will be on ram_q next cycle
    always_comb begin
        w_rd_state_nxt = RD_IDLE;
        if (w_cpu_rd_gnt) begin
            w_rd_state_nxt = rd_launch(OWNER_CPU, 1'b0);
        end else if (w_dma_gnt) begin
            w_rd_state_nxt = rd_launch(OWNER_DMA, dma_we);
        end
    end

    // Read-pipe state register; reset drops any in-flight read
    always_ff @(posedge clk) begin
        if (reset) begin
            r_rd_state <= RD_IDLE;
        end else begin
            r_rd_state <= w_rd_state_nxt;
        end
    end

    // Park a CPU read that could not be granted on its request cycle
    always_ff @(posedge clk) begin
        if (reset) begin
            r_pend      <= 1'b0;
            r_pend_addr <= '0;
        end else if (w_cpu_rd_gnt) begin
            r_pend <= 1'b0;
        end else if (cpu_rd_req) begin
            r_pend      <= 1'b1;
            r_pend_addr <= cpu_addr;
        end
    end

    // Hold the RAM address steady while nobody owns the port
    always_ff @(posedge clk) begin
        if (reset) begin
            r_last_addr <= '0;
        end else if (w_owner != OWNER_NONE) begin
            r_last_addr <= w_addr;
        end
    end

    // Stall the CPU from request until its data has been captured
    always_ff @(posedge clk) begin
        if (reset) begin
            r_ready   <= 1'b1;
            r_rd_data <= '0;
        end else if (r_rd_state == RD_CPU) begin
            r_ready   <= 1'b1;
            r_rd_data <= ram_q;
        end else if (cpu_rd_req) begin
            r_ready <= 1'b0;
        end
    end

    assign cpu_ready    = r_ready;
    assign cpu_rd_data  = r_rd_data;
    assign dma_ack      = w_dma_gnt;
    assign dma_rd_valid = (r_rd_state == RD_DMA) && !reset;
    assign dma_rd_data  = ram_q;
    assign ram_addr     = w_addr;
    assign ram_wr_data  = w_wdata;
    assign ram_wren     = w_wren;

`ifndef SYNTHESIS
    // Requester protocol checks
    a_cpu_rd_overlap: assert property (
        @(posedge clk) disable iff (reset)
        cpu_rd_req |-> (!r_pend && r_ready)
    );
    a_dma_req_hold: assert property (
        @(posedge clk) disable iff (reset)
        (dma_req && !dma_ack) |=> dma_req
    );
`endif

endmodule

// File: doc/ram_arbiter.md
Name: ram_arbiter

Overview:
Shares the single-port system block RAM (1-cycle registered read latency) between the CPU bus and a DMA/video fetch requester.
- Each cycle, grants the RAM port to at most one requester.
- Converts the CPU's one-cycle rd_req pulse into a stall (cpu_ready low) until the read data is returned.
- Sits between the CPU/address decode and the spram instance. Its inputs are already qualified by ram chip-select.

Parameters:
ADDR_WIDTH, 16, RAM address width
DATA_WIDTH, 8, RAM data width
MAX_WAIT, 4, cycles a pending CPU read may lose to DMA before it is forced through; 0 = CPU always beats DMA

Ports:
clk  in  1  system clock; single clock domain
reset  in  1  synchronous, active-high reset
cpu_addr  in  ADDR_WIDTH  CPU address
cpu_rd_req  in  1  one-cycle read request pulse, already qualified by ram chip-select
cpu_wr_en  in  1  one-cycle write strobe, already qualified by ram chip-select
cpu_wr_data  in  DATA_WIDTH  CPU write data
cpu_rd_data  out  DATA_WIDTH  registered CPU read data
cpu_ready  out  1  low while a CPU read is outstanding
dma_addr  in  ADDR_WIDTH  DMA address
dma_req  in  1  DMA request; held until acked
dma_we  in  1  DMA request is a write
dma_wr_data  in  DATA_WIDTH  DMA write data
dma_ack  out  1  combinational; DMA request granted this cycle
dma_rd_valid  out  1  DMA read data valid
dma_rd_data  out  DATA_WIDTH  DMA read data (ram_q passthrough)
ram_addr  out  ADDR_WIDTH  to spram
ram_wr_data  out  DATA_WIDTH  to spram
ram_wren  out  1  to spram
ram_q  in  DATA_WIDTH  from spram

Behaviour:
- Grant cycle T, combinational; priority evaluated in this order:
  1. cpu_wr_en=1: CPU write. ram_wren=1, ram_addr=cpu_addr. No stall. DMA not acked.
  2. CPU read is live (cpu_rd_req this cycle, or pending) and any of: dma_req=0, wait_cnt==MAX_WAIT, or MAX_WAIT=0. Then grant the CPU read.
  3. dma_req=1: dma_ack=1, ram_addr=dma_addr, ram_wren=dma_we.
  4. Otherwise: ram_wren=0, ram_addr holds the last value.
- CPU read pending flag:
  - Set when cpu_rd_req is not granted in its own cycle.
  - This includes cpu_rd_req coinciding with cpu_wr_en: the write wins and the read is pended.
  - cpu_addr is latched into the pending register at that time.
  - Cleared on grant.
- wait_cnt:
  - Increments, saturating at MAX_WAIT, each cycle a pending CPU read loses to DMA.
  - Cleared on CPU read grant and on reset.
- cpu_ready (registered):
  - 0 from T0+1, where T0 is the cycle cpu_rd_req is sampled, through the cycle after the grant cycle Tg.
  - Returns to 1 at Tg+2, together with cpu_rd_data, which is captured from ram_q at the end of Tg+1.
  - cpu_rd_data holds until the next CPU read completes.
- Uncontended CPU read: ready low for exactly 1 cycle; data visible 2 cycles after the request.
- DMA read granted at T: dma_rd_valid=1 and dma_rd_data=ram_q at T+1.
- Back-to-back grants are allowed: one grant per cycle, fully pipelined.
- Protocol errors (assertions, not handled in RTL):
  - cpu_rd_req while a read is pending or cpu_ready=0.
  - dma_req dropped before dma_ack.
- Reset:
  - cpu_ready=1, cpu_rd_data=0, dma_rd_valid=0, dma_ack=0, ram_wren=0, ram_addr=0.
  - pending=0, wait_cnt=0.
  - Any in-flight read is discarded: no dma_rd_valid, no cpu_rd_data update.

Optional Feature:
RAM_ARB_ROUND_ROBIN_EN
- Defined: when a CPU read and a DMA request contend, the winner alternates based on a last_owner register (reset value = CPU, so DMA wins first). MAX_WAIT and wait_cnt are unused. Rule 1, the CPU write, still wins unconditionally.
- Undefined: fixed DMA priority with MAX_WAIT starvation bound, as described above.

Decomposition:
- Package ram_arb_pkg holds:
  - Owner encoding: OWNER_NONE=2'd0, OWNER_CPU=2'd1, OWNER_DMA=2'd2.
  - Read-pipe state encoding: RD_IDLE, RD_CPU, RD_DMA.
- One natural sub-module: ram_arb_wait_cnt, the saturating counter with clear/increment and an at-limit output.

Test Plan:
1. Reset, then CPU write 0x8000←0x5A followed by cpu_rd_req at 0x8000 with no DMA → cpu_ready low 1 cycle; cpu_rd_data=0x5A 2 cycles after the request.
2. dma_req held continuously for reads at 0x0100..0x0107, preloaded 0x00..0x07 → dma_ack every cycle; dma_rd_valid 8 consecutive cycles, each 1 cycle after its ack, with data 0x00..0x07 in order.
3. DMA streaming plus CPU read at 0x0200 with MAX_WAIT=4 → CPU granted on the 5th cycle after the request; cpu_ready low 6 cycles; that cycle DMA gets no ack.
4. cpu_wr_en and cpu_rd_req in the same cycle, plus dma_req → write committed that cycle; DMA granted next cycle; CPU read granted the cycle after that if DMA then drops.
5. Assert reset in the cycle after a DMA read grant → no dma_rd_valid; all outputs at reset values next cycle.
6. With RAM_ARB_ROUND_ROBIN_EN defined: continuous DMA plus two sequential CPU reads → grants alternate DMA, CPU, DMA, CPU; each CPU read costs exactly 2 ready-low cycles.
